dsp_vec_selftest: RTL and testbench

DSP_VEC_SELFTEST -- requirements
Module: dsp_vec_selftest

---
 rtl/dsp_vec_selftest_if.sv | 14 +
 rtl/dsp_vec_selftest.sv | 248 ++++++++++++++++++++++++
 tb/tb_dsp_vec_selftest.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_vec_selftest_if.sv
// Operand/result bus between the vector self-test engine and the DSP block under test.
// The self-test drives the operands and valid_out; the DSP block returns y.
interface dsp_vec_selftest_if #(
  parameter int WIDTH = 12,
  parameter int LANES = 4
);
  logic [LANES*WIDTH-1:0] a;
  logic [LANES*WIDTH-1:0] b;
  logic                   valid_out;
  logic [LANES*WIDTH-1:0] y;

  modport master (output a, output b, output valid_out, input y);
  modport slave  (input a, input b, input valid_out, output y);
endinterface

// File: rtl/dsp_vec_selftest.sv
// LFSR-driven SIMD vector self-test: issues NUM_VEC operand vectors, checks y against a lanewise reference.
// Optional first-mismatch capture is built when DSP_SELFTEST_TRACE_EN is defined.
module dsp_vec_selftest #(
  parameter int          WIDTH   = 12,
  parameter int          LANES   = 4,
  parameter int          LATENCY = 2,
  parameter int          NUM_VEC = 16,
  parameter int          OP      = 0,
  parameter logic [31:0] SEED    = 32'hACE10001
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  dsp_vec_selftest_if.master       vec,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              err_count,
  output logic [15:0]              vec_count,
  output logic [15:0]              first_fail_idx,
  output logic [LANES*WIDTH-1:0]   first_fail_exp,
  output logic [LANES*WIDTH-1:0]   first_fail_act
);

  localparam int          VW   = LANES * WIDTH;
  localparam logic [31:0] TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? TAPS : 32'h0000_0000);
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] s, input logic [4:0] r);
    rotl = (s << r) | (s >> (6'd32 - {1'b0, r}));
  endfunction

  function automatic logic [VW-1:0] make_a(input logic [31:0] s);
    logic [31:0] r;
    make_a = '0;
    for (int i = 0; i < LANES; i++) begin
      r = rotl(s, 5'(5 * i));
      make_a[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
    end
  endfunction

  function automatic logic [VW-1:0] make_b(input logic [31:0] s);
    logic [31:0] r;
    make_b = '0;
    for (int i = 0; i < LANES; i++) begin
      r = rotl(~s, 5'(7 * i));
      make_b[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
    end
  endfunction

  // Lanewise reference operation; each lane wraps modulo 2^WIDTH.
  function automatic logic [VW-1:0] apply_op(input logic [VW-1:0] x, input logic [VW-1:0] z);
    logic [WIDTH-1:0] xl;
    logic [WIDTH-1:0] zl;
    apply_op = '0;
    for (int i = 0; i < LANES; i++) begin
      xl = x[i*WIDTH +: WIDTH];
      zl = z[i*WIDTH +: WIDTH];
      case (OP)
        0:       apply_op[i*WIDTH +: WIDTH] = xl + zl;
        1:       apply_op[i*WIDTH +: WIDTH] = xl - zl;
        2:       apply_op[i*WIDTH +: WIDTH] = xl & zl;
        3:       apply_op[i*WIDTH +: WIDTH] = xl | zl;
        4:       apply_op[i*WIDTH +: WIDTH] = xl ^ zl;
        default: apply_op[i*WIDTH +: WIDTH] = '0;
      endcase
    end
  endfunction

  state_t          state_r;
  logic [31:0]     lfsr_r;
  logic [15:0]     issue_cnt_r;
  logic [VW-1:0]   a_r;
  logic [VW-1:0]   b_r;
  logic            valid_r;
  logic [VW-1:0]   exp_r;
  logic [VW-1:0]   exp_pipe_r [LATENCY];
  logic            vld_pipe_r [LATENCY];

  logic            start_s;
  logic            cmp_valid_s;
  logic [VW-1:0]   cmp_exp_s;
  logic            mismatch_s;
  logic [15:0]     err_next_s;
  logic            last_issue_s;
  logic            last_cmp_s;

  assign vec.a         = a_r;
  assign vec.b         = b_r;
  assign vec.valid_out = valid_r;

  // Compare stage decode: delayed expected word against the returned result.
  always_comb begin
    start_s      = 1'b0;
    cmp_valid_s  = vld_pipe_r[LATENCY-1];
    cmp_exp_s    = exp_pipe_r[LATENCY-1];
    mismatch_s   = 1'b0;
    err_next_s   = err_count;
    last_issue_s = (issue_cnt_r == 16'(NUM_VEC - 1));
    last_cmp_s   = 1'b0;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      start_s = start;
    end else begin
      start_s = 1'b0;
    end
    if (cmp_valid_s) begin
      mismatch_s = (vec.y != cmp_exp_s);
      last_cmp_s = (vec_count == 16'(NUM_VEC - 1));
    end else begin
      mismatch_s = 1'b0;
      last_cmp_s = 1'b0;
    end
    if (mismatch_s && (err_count != 16'hFFFF)) begin
      err_next_s = err_count + 16'd1;
    end else begin
      err_next_s = err_count;
    end
  end

  // Run-control FSM with operand issue, expected-word pipeline and result counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= IDLE;
      lfsr_r      <= SEED;
      issue_cnt_r <= 16'd0;
      a_r         <= '0;
      b_r         <= '0;
      valid_r     <= 1'b0;
      exp_r       <= '0;
      for (int j = 0; j < LATENCY; j++) begin
        exp_pipe_r[j] <= '0;
        vld_pipe_r[j] <= 1'b0;
      end
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= 16'd0;
      vec_count   <= 16'd0;
    end else begin
      exp_pipe_r[0] <= exp_r;
      vld_pipe_r[0] <= valid_r;
      for (int j = 1; j < LATENCY; j++) begin
        exp_pipe_r[j] <= exp_pipe_r[j-1];
        vld_pipe_r[j] <= vld_pipe_r[j-1];
      end
      if (cmp_valid_s) begin
        vec_count <= vec_count + 16'd1;
        err_count <= err_next_s;
      end else begin
        vec_count <= vec_count;
      end
      // Operands are only live in cycles where a vector is issued.
      a_r     <= '0;
      b_r     <= '0;
      exp_r   <= '0;
      valid_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start_s) begin
            state_r     <= RUN;
            lfsr_r      <= SEED;
            issue_cnt_r <= 16'd0;
            err_count   <= 16'd0;
            vec_count   <= 16'd0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          a_r         <= make_a(lfsr_r);
          b_r         <= make_b(lfsr_r);
          exp_r       <= apply_op(make_a(lfsr_r), make_b(lfsr_r));
          valid_r     <= 1'b1;
          lfsr_r      <= lfsr_step(lfsr_r);
          issue_cnt_r <= issue_cnt_r + 16'd1;
          if (last_issue_s) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if (last_cmp_s) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next_s == 16'd0);
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DSP_SELFTEST_TRACE_EN
  logic [15:0]   ff_idx_r;
  logic [VW-1:0] ff_exp_r;
  logic [VW-1:0] ff_act_r;

  // Latch the first mismatching compare of each run; later mismatches leave it alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ff_idx_r <= 16'd0;
      ff_exp_r <= '0;
      ff_act_r <= '0;
    end else if (start_s) begin
      ff_idx_r <= 16'd0;
      ff_exp_r <= '0;
      ff_act_r <= '0;
    end else if (mismatch_s && (err_count == 16'd0)) begin
      ff_idx_r <= vec_count;
      ff_exp_r <= cmp_exp_s;
      ff_act_r <= vec.y;
    end else begin
      ff_idx_r <= ff_idx_r;
    end
  end

  assign first_fail_idx = ff_idx_r;
  assign first_fail_exp = ff_exp_r;
  assign first_fail_act = ff_act_r;
`else
  assign first_fail_idx = 16'd0;
  assign first_fail_exp = '0;
  assign first_fail_act = '0;
`endif

endmodule

// File: tb/tb_dsp_vec_selftest.sv
// Scoreboard bench for dsp_vec_selftest with a behavioural add-with-delay DSP model and fault injection.
module tb_dsp_vec_selftest;

  localparam int          WIDTH   = 12;
  localparam int          LANES   = 4;
  localparam int          LATENCY = 2;
  localparam int          NUM_VEC = 16;
  localparam int          VW      = WIDTH * LANES;
  localparam logic [31:0] SEED    = 32'hACE10001;
  localparam logic [31:0] TAPS    = 32'h80200003;
  localparam int          BUDGET  = 200;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   err_count, vec_count, first_fail_idx;
  logic [VW-1:0] first_fail_exp, first_fail_act;

  dsp_vec_selftest_if #(.WIDTH(WIDTH), .LANES(LANES)) vif ();

  dsp_vec_selftest #(
    .WIDTH(WIDTH), .LANES(LANES), .LATENCY(LATENCY), .NUM_VEC(NUM_VEC), .OP(0), .SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .vec(vif),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_count(vec_count),
    .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp), .first_fail_act(first_fail_act)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  logic [VW-1:0] ref_a [NUM_VEC];
  logic [VW-1:0] ref_b [NUM_VEC];
  logic [VW-1:0] ref_y [NUM_VEC];
  logic [VW-1:0] exp_a_q [$];
  logic [VW-1:0] exp_b_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] rotl_bits(input logic [31:0] s, input int n);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = {t[30:0], t[31]};
    return t;
  endfunction

  function automatic logic [VW-1:0] lane_add(input logic [VW-1:0] x, input logic [VW-1:0] z);
    logic [VW-1:0] r;
    logic [31:0]   mask, xl, zl;
    mask = (32'd1 << WIDTH) - 32'd1;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      xl = 32'((x >> (i * WIDTH))) & mask;
      zl = 32'((z >> (i * WIDTH))) & mask;
      r = r | (VW'((xl + zl) & mask) << (i * WIDTH));
    end
    return r;
  endfunction

  // Reference vectors straight from the LFSR/rotation rules.
  task automatic build_reference();
    logic [31:0] st, mask;
    mask = (32'd1 << WIDTH) - 32'd1;
    st = SEED;
    for (int k = 0; k < NUM_VEC; k++) begin
      ref_a[k] = '0;
      ref_b[k] = '0;
      for (int i = 0; i < LANES; i++) begin
        ref_a[k] = ref_a[k] | (VW'(rotl_bits(st, 5 * i) & mask) << (i * WIDTH));
        ref_b[k] = ref_b[k] | (VW'(rotl_bits(~st, 7 * i) & mask) << (i * WIDTH));
      end
      ref_y[k] = lane_add(ref_a[k], ref_b[k]);
      st = st[0] ? ((st >> 1) ^ TAPS) : (st >> 1);
    end
  endtask

  // DSP block model: lanewise add, two-cycle delay, optional fault on the result.
  int            fault_mode = 0;
  int            mdl_idx = 0;
  logic [VW-1:0] mdl_d1 = '0;
  logic [VW-1:0] mdl_y = '0;

  function automatic logic [VW-1:0] mdl_out(input logic [VW-1:0] x, input logic [VW-1:0] z,
                                            input logic v, input int idx);
    logic [VW-1:0] r;
    r = lane_add(x, z);
    if (v && fault_mode == 1 && idx == 5) r = r ^ (VW'(1) << (2 * WIDTH));
    else if (v && fault_mode == 2) r = ~r;
    return r;
  endfunction

  always @(posedge clock) begin
    mdl_d1 <= mdl_out(vif.a, vif.b, vif.valid_out, mdl_idx);
    mdl_y  <= mdl_d1;
    if (vif.valid_out) mdl_idx <= mdl_idx + 1;
    else if (busy === 1'b0) mdl_idx <= 0;
  end
  assign vif.y = mdl_y;

  // Monitor: pops the scoreboard whenever a vector is presented, else expects idle-zero operands.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (vif.valid_out === 1'b1) begin
        if (exp_a_q.size() == 0) begin
          checks++;
          $display("FAIL vec_extra: valid_out with a=%0h, expected no vector", vif.a);
        end else begin
          check("vec_a", vif.a, exp_a_q.pop_front());
          check("vec_b", vif.b, exp_b_q.pop_front());
        end
      end else begin
        check("idle_ab", {vif.valid_out, vif.a, vif.b}, '0);
      end
    end
  end

  task automatic push_run();
    for (int k = 0; k < NUM_VEC; k++) begin
      exp_a_q.push_back(ref_a[k]);
      exp_b_q.push_back(ref_b[k]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, pass, err_count, vec_count, vif.valid_out}, '0);
    check({tag, "_ab"}, {vif.a, vif.b}, '0);
    check({tag, "_ff"}, {first_fail_idx, first_fail_exp, first_fail_act}, '0);
  endtask

  task automatic start_run(input bit hold);
    @(negedge clock);
    start = 1'b1;
    push_run();
    @(posedge clock);
    #1;
    check("busy_at_start", busy, 1'b1);
    @(negedge clock);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int abort_at, output int done_cyc, output int first_v, output int last_v);
    done_cyc = -1;
    first_v  = -1;
    last_v   = -1;
    if (abort_at == 1) reset = 1'b0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clock);
      #1;
      if (vif.valid_out === 1'b1) begin
        if (first_v < 0) first_v = n;
        last_v = n;
      end
      if (abort_at == n) begin
        check_all_zero("abort");
        exp_a_q.delete();
        exp_b_q.delete();
        done_cyc = n;
        break;
      end
      if (done === 1'b1) begin
        done_cyc = n;
        break;
      end
      @(negedge clock);
      if (abort_at == n + 1) reset = 1'b0;
    end
    if (done_cyc < 0) check("done_timeout", done, 1'b1);
  endtask

  task automatic check_run(input string tag, input int dc, input int fv, input int lv,
                           input int e_err, input bit e_pass);
    check({tag, "_done_cycle"}, dc, NUM_VEC + LATENCY + 1);
    check({tag, "_first_valid"}, fv, 1);
    check({tag, "_last_valid"}, lv, NUM_VEC);
    check({tag, "_err"}, err_count, e_err);
    check({tag, "_vec"}, vec_count, NUM_VEC);
    check({tag, "_pass"}, pass, e_pass);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_sb_empty"}, exp_a_q.size(), 0);
  endtask

  int dc, fv, lv;

  initial begin
    build_reference();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // Clean run.
    fault_mode = 0;
    start_run(1'b0);
    wait_done(0, dc, fv, lv);
    check_run("clean", dc, fv, lv, 0, 1'b1);
    check("clean_ff", {first_fail_idx, first_fail_exp, first_fail_act}, '0);
    repeat (3) @(posedge clock);
    #1;
    check("done_holds", {done, pass}, 2'b11);

    // Single-lane, single-bit fault on vector 5.
    fault_mode = 1;
    start_run(1'b0);
    wait_done(0, dc, fv, lv);
    check_run("fault1", dc, fv, lv, 1, 1'b0);
`ifdef DSP_SELFTEST_TRACE_EN
    check("fault1_idx", first_fail_idx, 16'd5);
    check("fault1_exp", first_fail_exp, ref_y[5]);
    check("fault1_diff", first_fail_exp ^ first_fail_act, VW'(1) << 24);
`else
    check("fault1_ff", {first_fail_idx, first_fail_exp, first_fail_act}, '0);
`endif

    // Every result inverted.
    fault_mode = 2;
    start_run(1'b0);
    wait_done(0, dc, fv, lv);
    check_run("invert", dc, fv, lv, NUM_VEC, 1'b0);
`ifdef DSP_SELFTEST_TRACE_EN
    check("invert_idx", first_fail_idx, 16'd0);
    check("invert_act", first_fail_act, ~ref_y[0]);
`else
    check("invert_ff", {first_fail_idx, first_fail_exp, first_fail_act}, '0);
`endif

    // Reset at cycle 8 of a run, then a fresh run.
    fault_mode = 0;
    start_run(1'b0);
    wait_done(8, dc, fv, lv);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("abort_no_compare", {busy, done, err_count, vec_count}, '0);
    start_run(1'b0);
    wait_done(0, dc, fv, lv);
    check_run("rerun", dc, fv, lv, 0, 1'b1);

    // start held high: one run, then a new run right after DONE.
    start_run(1'b1);
    wait_done(0, dc, fv, lv);
    check_run("hold1", dc, fv, lv, 0, 1'b1);
    push_run();
    @(posedge clock);
    #1;
    check("hold_restart", {done, busy}, 2'b01);
    @(negedge clock);
    start = 1'b0;
    wait_done(0, dc, fv, lv);
    check_run("hold2", dc, fv, lv, 0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
